// File: rtl/vector_alu_ctrl.sv
// Issue/writeback controller for the 2-stage vector_alu: tracks destination tags
// alongside the ALU pipeline, stalls on RAW hazards and on writeback backpressure.
module vector_alu_ctrl #(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [4:0]       iss_op,
    input  logic [7:0]       iss_imm,
    input  logic [TAG_W-1:0] iss_dst,
    input  logic [TAG_W-1:0] iss_src1,
    input  logic [TAG_W-1:0] iss_src2,
    input  logic             iss_src1_vec,
    input  logic             iss_src2_vec,
    input  logic             iss_use_src2,
    input  logic             flush,

    output logic [4:0]       alu_op,
    output logic [7:0]       alu_imm,
    output logic             alu_en,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_dst,
    output logic             wb_is_vec,

    output logic             illegal_op,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [4:0] OP_MAX = 5'd18;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] dst;
        logic             is_vec;
        logic [7:0]       imm;
    } stage_t;

    stage_t           s1_q;
    stage_t           s2_q;
    stage_t           s1_d;
    logic             illegal_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] retired_q;

    logic stall;
    logic src1_hit;
    logic src2_hit;
    logic hazard;
    logic accept;
    logic op_legal;
    logic retire;

    // Scalar-result ops: Fadd, Fsub, Fmult, Vdot, Vdota, Vindx, Vreduce.
    function automatic logic writes_vec(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9: writes_vec = 1'b0;
            default:                                   writes_vec = 1'b1;
        endcase
    endfunction

    function automatic logic tag_hit(input stage_t s, input logic [TAG_W-1:0] tag,
                                     input logic vec);
        tag_hit = s.valid && (s.dst == tag) && (s.is_vec == vec);
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value held over and no latch is inferred.
    always_comb begin
        stall    = s2_q.valid && !wb_ready;
        src1_hit = tag_hit(s1_q, iss_src1, iss_src1_vec) ||
                   tag_hit(s2_q, iss_src1, iss_src1_vec);
        src2_hit = iss_use_src2 &&
                   (tag_hit(s1_q, iss_src2, iss_src2_vec) ||
                    tag_hit(s2_q, iss_src2, iss_src2_vec));
        // Conservative: an S2 entry retiring this cycle still blocks its readers.
        hazard   = iss_valid && (src1_hit || src2_hit);

        iss_ready = !rst && !stall && !hazard && !flush;
        accept    = iss_valid && iss_ready;
        op_legal  = (iss_op <= OP_MAX);
        retire    = s2_q.valid && wb_ready;

        alu_en = !rst && !stall;
        alu_op = '0;
        s1_d   = '0;
        if (accept && op_legal) begin
            alu_op      = iss_op;
            s1_d.valid  = 1'b1;
            s1_d.dst    = iss_dst;
            s1_d.is_vec = writes_vec(iss_op);
            s1_d.imm    = iss_imm;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; S2 <= S1 relies on this.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            illegal_q <= 1'b0;
            issued_q  <= '0;
            retired_q <= '0;
        end else begin
            illegal_q <= accept && !op_legal;
            if (accept && op_legal) issued_q <= issued_q + CNT_W'(1);
            if (retire)             retired_q <= retired_q + CNT_W'(1);

            // Flush wins over both advance and stall.
            if (flush) begin
                s1_q.valid <= 1'b0;
                s2_q.valid <= 1'b0;
            end else if (!stall) begin
                s2_q <= s1_q;
                s1_q <= s1_d;
            end
        end
    end

    // The ALU samples imm at its output stage, so it follows S2.
    assign alu_imm     = s2_q.imm;
    assign wb_valid    = s2_q.valid;
    assign wb_dst      = s2_q.dst;
    assign wb_is_vec   = s2_q.is_vec;
    assign illegal_op  = illegal_q;
    assign busy        = s1_q.valid || s2_q.valid;
    assign issued_cnt  = issued_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_vector_alu_ctrl.sv
// Self-checking bench for vector_alu_ctrl: directed test-plan scenarios plus a
// randomized run against an in-flight-list reference model.
module tb_vector_alu_ctrl;

    localparam int TAG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [4:0] OP_FMULT = 5'd2;
    localparam logic [4:0] OP_VADD  = 5'd3;
    localparam logic [4:0] OP_VSUB  = 5'd4;
    localparam logic [4:0] OP_VMULT = 5'd5;
    localparam logic [4:0] OP_VINDX = 5'd8;
    localparam logic [4:0] OP_VSWZ  = 5'd10;

    logic             clk = 1'b0;
    logic             rst;
    logic             iss_valid, iss_ready;
    logic [4:0]       iss_op;
    logic [7:0]       iss_imm;
    logic [TAG_W-1:0] iss_dst, iss_src1, iss_src2;
    logic             iss_src1_vec, iss_src2_vec, iss_use_src2;
    logic             flush;
    logic [4:0]       alu_op;
    logic [7:0]       alu_imm;
    logic             alu_en;
    logic             wb_valid, wb_ready, wb_is_vec;
    logic [TAG_W-1:0] wb_dst;
    logic             illegal_op, busy;
    logic [CNT_W-1:0] issued_cnt, retired_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    vector_alu_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_imm(iss_imm),
        .iss_dst(iss_dst), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_src1_vec(iss_src1_vec), .iss_src2_vec(iss_src2_vec), .iss_use_src2(iss_use_src2),
        .flush(flush), .alu_op(alu_op), .alu_imm(alu_imm), .alu_en(alu_en),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_is_vec(wb_is_vec),
        .illegal_op(illegal_op), .busy(busy), .issued_cnt(issued_cnt), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: list of in-flight instructions, each tagged with the
    // pipeline stage (1 or 2) it currently occupies; bubbles are not stored.
    typedef struct {
        logic [TAG_W-1:0] dst;
        logic             vec;
        logic [7:0]       imm;
        int               stage;
    } rec_t;

    rec_t             inflight[$];
    logic             m_illegal = 1'b0;
    logic [CNT_W-1:0] m_issued  = '0;
    logic [CNT_W-1:0] m_retired = '0;

    function automatic logic op_writes_vec(input logic [4:0] op);
        return !(op inside {5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9});
    endfunction

    function automatic int m_out_idx();
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i].stage == 2) return i;
        return -1;
    endfunction

    function automatic logic m_hit(input logic [TAG_W-1:0] tag, input logic vec);
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i].dst == tag && inflight[i].vec == vec) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_stall();
        return (m_out_idx() >= 0) && !wb_ready;
    endfunction

    function automatic logic m_ready();
        logic hz;
        hz = iss_valid && (m_hit(iss_src1, iss_src1_vec) ||
                           (iss_use_src2 && m_hit(iss_src2, iss_src2_vec)));
        return !rst && !m_stall() && !hz && !flush;
    endfunction

    task automatic model_update();
        rec_t keep[$];
        rec_t r;
        logic stall, acc, legal;
        int   oi;
        oi    = m_out_idx();
        stall = m_stall();
        acc   = iss_valid && m_ready();
        legal = (iss_op <= 5'd18);
        if (rst) begin
            inflight.delete();
            m_illegal = 1'b0;
            m_issued  = '0;
            m_retired = '0;
            return;
        end
        if (oi >= 0 && wb_ready) m_retired = m_retired + 1'b1;
        if (acc && legal)        m_issued  = m_issued + 1'b1;
        m_illegal = acc && !legal;
        if (flush) begin
            inflight.delete();
        end else if (!stall) begin
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i].stage == 1) begin
                    r = inflight[i];
                    r.stage = 2;
                    keep.push_back(r);
                end
            end
            if (acc && legal) begin
                r.dst = iss_dst; r.vec = op_writes_vec(iss_op); r.imm = iss_imm; r.stage = 1;
                keep.push_back(r);
            end
            inflight = keep;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_op = '0; iss_imm = '0; iss_dst = '0;
        iss_src1 = '0; iss_src2 = '0; iss_src1_vec = 1'b0; iss_src2_vec = 1'b0;
        iss_use_src2 = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    endtask

    task automatic offer(input logic [4:0] op, input logic [TAG_W-1:0] dst,
                         input logic [TAG_W-1:0] s1, input logic s1v,
                         input logic [TAG_W-1:0] s2, input logic s2v,
                         input logic use2, input logic [7:0] imm);
        iss_valid = 1'b1; iss_op = op; iss_dst = dst; iss_imm = imm;
        iss_src1 = s1; iss_src1_vec = s1v; iss_src2 = s2; iss_src2_vec = s2v;
        iss_use_src2 = use2;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        offer(OP_VADD, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 8'h55);
        tick();
        #1;
        n_cmp++;
        if ({iss_ready, alu_en, alu_op, alu_imm, wb_valid, wb_dst, wb_is_vec,
             illegal_op, busy, issued_cnt, retired_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b en=%b op=%0d imm=%h wbv=%b dst=%0d vec=%b ill=%b busy=%b iss=%0d ret=%0d, want all 0",
                     iss_ready, alu_en, alu_op, alu_imm, wb_valid, wb_dst, wb_is_vec,
                     illegal_op, busy, issued_cnt, retired_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (iss_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_first_ready: got %b want 1", iss_ready);
        end
        tick();
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_independent();
        logic [4:0] ops [3];
        logic [4:0] dsts[3];
        logic       vecs[3];
        ops  = '{OP_VADD, OP_FMULT, OP_VSUB};
        dsts = '{5'd1, 5'd2, 5'd3};
        vecs = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) offer(ops[c], dsts[c], 5'(20 + c), 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
            else       idle_inputs();
            #1;
            if (c < 3) begin
                n_cmp++;
                if ({iss_ready, alu_en, alu_op} !== {1'b1, 1'b1, ops[c]}) begin
                    n_bad++;
                    $display("FAIL indep_issue_c%0d: rdy=%b en=%b op=%0d want 1 1 %0d",
                             c, iss_ready, alu_en, alu_op, ops[c]);
                end
            end
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if ({wb_valid, wb_dst, wb_is_vec} !== {1'b1, dsts[c-2], vecs[c-2]}) begin
                    n_bad++;
                    $display("FAIL indep_wb_c%0d: v=%b dst=%0d vec=%b want 1 %0d %b",
                             c, wb_valid, wb_dst, wb_is_vec, dsts[c-2], vecs[c-2]);
                end
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({wb_valid, issued_cnt, retired_cnt} !== {1'b0, 16'd3, 16'd3}) begin
            n_bad++;
            $display("FAIL indep_counts: wbv=%b issued=%0d retired=%0d want 0 3 3",
                     wb_valid, issued_cnt, retired_cnt);
        end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        offer(OP_VADD, 5'd4, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VMULT, 5'd5, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_cmp++;
            if (iss_ready !== (c == 3)) begin
                n_bad++;
                $display("FAIL raw_ready_c%0d: got %b want %b", c, iss_ready, c == 3);
            end
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
        // Scalar r4 must not collide with vector v4 in flight.
        offer(OP_VADD, 5'd4, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VMULT, 5'd5, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
        #1;
        n_cmp++;
        if (iss_ready !== 1'b1) begin
            n_bad++; $display("FAIL raw_scalar_src: got %b want 1", iss_ready);
        end
        tick();
        // v4 now in S2: used src2 stalls, unused src2 does not.
        offer(OP_VSUB, 5'd6, 5'd12, 1'b1, 5'd4, 1'b1, 1'b1, 8'h00);
        #1;
        n_cmp++;
        if (iss_ready !== 1'b0) begin
            n_bad++; $display("FAIL raw_src2_used: got %b want 0", iss_ready);
        end
        iss_use_src2 = 1'b0;
        #1;
        n_cmp++;
        if (iss_ready !== 1'b1) begin
            n_bad++; $display("FAIL raw_src2_unused: got %b want 1", iss_ready);
        end
        tick();
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        offer(OP_VADD, 5'd6, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VSUB, 5'd7, 5'd21, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VADD, 5'd10, 5'd22, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({alu_en, iss_ready, wb_valid, wb_dst} !== {1'b0, 1'b0, 1'b1, 5'd6}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: en=%b rdy=%b wbv=%b dst=%0d want 0 0 1 6",
                         k, alu_en, iss_ready, wb_valid, wb_dst);
            end
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if ({wb_valid, wb_dst} !== ((k == 0) ? {1'b1, 5'd6} : (k == 1) ? {1'b1, 5'd7} : {1'b0, wb_dst})) begin
                n_bad++;
                $display("FAIL bp_release_%0d: wbv=%b dst=%0d", k, wb_valid, wb_dst);
            end
            tick();
        end
        n_cmp++;
        if (retired_cnt !== 16'd2) begin
            n_bad++; $display("FAIL bp_retired: got %0d want 2", retired_cnt);
        end
    endtask

    task automatic test_imm_align();
        do_reset();
        offer(OP_VSWZ, 5'd8, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h1B);
        tick();
        offer(OP_VINDX, 5'd9, 5'd21, 1'b1, 5'd0, 1'b0, 1'b0, 8'h02);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({wb_valid, alu_imm} !== {1'b1, 8'h1B}) begin
            n_bad++; $display("FAIL imm_c2: wbv=%b imm=%h want 1 1b", wb_valid, alu_imm);
        end
        tick();
        n_cmp++;
        if ({wb_valid, alu_imm, wb_is_vec} !== {1'b1, 8'h02, 1'b0}) begin
            n_bad++; $display("FAIL imm_c3: wbv=%b imm=%h vec=%b want 1 02 0", wb_valid, alu_imm, wb_is_vec);
        end
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        offer(5'd25, 5'd3, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        #1;
        n_cmp++;
        if (iss_ready !== 1'b1) begin
            n_bad++; $display("FAIL illegal_accept: got %b want 1", iss_ready);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({illegal_op, wb_valid} !== 2'b10) begin
            n_bad++; $display("FAIL illegal_pulse: ill=%b wbv=%b want 1 0", illegal_op, wb_valid);
        end
        tick();
        n_cmp++;
        if ({illegal_op, wb_valid, busy, issued_cnt} !== {3'b000, 16'd0}) begin
            n_bad++;
            $display("FAIL illegal_after: ill=%b wbv=%b busy=%b issued=%0d want 0 0 0 0",
                     illegal_op, wb_valid, busy, issued_cnt);
        end
        // Boundary: 19 is the first illegal opcode, 18 the last legal one.
        offer(5'd19, 5'd3, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(5'd18, 5'd11, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        #1;
        n_cmp++;
        if ({illegal_op, alu_op} !== {1'b1, 5'd18}) begin
            n_bad++; $display("FAIL illegal_19: ill=%b op=%0d want 1 18", illegal_op, alu_op);
        end
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if ({illegal_op, wb_valid, wb_dst, wb_is_vec, issued_cnt} !== {1'b0, 1'b1, 5'd11, 1'b1, 16'd1}) begin
            n_bad++;
            $display("FAIL legal_18: ill=%b wbv=%b dst=%0d vec=%b issued=%0d want 0 1 11 1 1",
                     illegal_op, wb_valid, wb_dst, wb_is_vec, issued_cnt);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        offer(OP_VADD, 5'd1, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VSUB, 5'd2, 5'd21, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VADD, 5'd3, 5'd22, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        wb_ready = 1'b0;
        flush    = 1'b1;
        #1;
        n_cmp++;
        if ({iss_ready, busy, wb_valid} !== 3'b011) begin
            n_bad++; $display("FAIL flush_cycle: rdy=%b busy=%b wbv=%b want 0 1 1", iss_ready, busy, wb_valid);
        end
        tick();
        idle_inputs();
        wb_ready = 1'b0;
        #1;
        n_cmp++;
        if ({wb_valid, busy, issued_cnt, retired_cnt} !== {2'b00, 16'd2, 16'd0}) begin
            n_bad++;
            $display("FAIL flush_after: wbv=%b busy=%b issued=%0d retired=%0d want 0 0 2 0",
                     wb_valid, busy, issued_cnt, retired_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        offer(OP_VADD, 5'd1, 5'd20, 1'b1, 5'd0, 1'b0, 1'b0, 8'h44);
        tick();
        offer(5'd30, 5'd2, 5'd21, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        tick();
        offer(OP_VSUB, 5'd3, 5'd22, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00);
        wb_ready = 1'b0;
        rst      = 1'b1;
        #1;
        n_cmp++;
        if ({iss_ready, alu_en, alu_op} !== '0) begin
            n_bad++; $display("FAIL rstmid_comb: rdy=%b en=%b op=%0d want 0 0 0", iss_ready, alu_en, alu_op);
        end
        tick();
        n_cmp++;
        if ({wb_valid, wb_dst, wb_is_vec, alu_imm, illegal_op, busy, issued_cnt, retired_cnt} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_regs: wbv=%b dst=%0d vec=%b imm=%h ill=%b busy=%b iss=%0d ret=%0d want all 0",
                     wb_valid, wb_dst, wb_is_vec, alu_imm, illegal_op, busy, issued_cnt, retired_cnt);
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int   oi;
        logic e_ready, e_en;
        logic [4:0] e_op;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 31) == 0);
            wb_ready     = ($urandom_range(0, 3) != 0);
            iss_valid    = ($urandom_range(0, 9) < 7);
            iss_op       = 5'($urandom_range(0, 21));
            iss_imm      = 8'($urandom);
            iss_dst      = 5'($urandom_range(0, 3));
            iss_src1     = 5'($urandom_range(0, 3));
            iss_src2     = 5'($urandom_range(0, 3));
            iss_src1_vec = 1'($urandom);
            iss_src2_vec = 1'($urandom);
            iss_use_src2 = 1'($urandom);
            #1;
            oi      = m_out_idx();
            e_ready = m_ready();
            e_en    = !rst && !m_stall();
            e_op    = (iss_valid && e_ready && iss_op <= 5'd18) ? iss_op : 5'd0;
            n_cmp++;
            if ({iss_ready, alu_en, alu_op} !== {e_ready, e_en, e_op}) begin
                n_bad++;
                $display("FAIL rnd_issue c%0d: rdy=%b en=%b op=%0d want %b %b %0d",
                         c, iss_ready, alu_en, alu_op, e_ready, e_en, e_op);
            end
            n_cmp++;
            if ({wb_valid, busy, illegal_op} !== {oi >= 0, inflight.size() != 0, m_illegal}) begin
                n_bad++;
                $display("FAIL rnd_status c%0d: wbv=%b busy=%b ill=%b want %b %b %b",
                         c, wb_valid, busy, illegal_op, oi >= 0, inflight.size() != 0, m_illegal);
            end
            if (oi >= 0) begin
                n_cmp++;
                if ({wb_dst, wb_is_vec, alu_imm} !== {inflight[oi].dst, inflight[oi].vec, inflight[oi].imm}) begin
                    n_bad++;
                    $display("FAIL rnd_wb c%0d: dst=%0d vec=%b imm=%h want %0d %b %h", c, wb_dst,
                             wb_is_vec, alu_imm, inflight[oi].dst, inflight[oi].vec, inflight[oi].imm);
                end
            end
            n_cmp++;
            if ({issued_cnt, retired_cnt} !== {m_issued, m_retired}) begin
                n_bad++;
                $display("FAIL rnd_counts c%0d: issued=%0d retired=%0d want %0d %0d",
                         c, issued_cnt, retired_cnt, m_issued, m_retired);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_independent();
        test_raw_hazard();
        test_backpressure();
        test_imm_align();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_alu_ctrl.md
# vector_alu_ctrl

Issue/writeback controller for the 2-stage `vector_alu`. It accepts one instruction per cycle over a valid/ready handshake and drives the ALU's `op`, `imm` and `en`. It tracks each in-flight instruction's destination tag alongside the ALU pipeline and stalls issue on read-after-write hazards. It presents completed results to the register-file writeback port under a second valid/ready handshake, stalling the datapath whenever writeback backpressures.

## Interface
Parameters:
- TAG_W, 5, register tag width (vector and scalar files each have 2^TAG_W entries)
- CNT_W, 16, width of the issued/retired counters

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  instruction offered
- iss_ready  out  1  instruction accepted this cycle when iss_valid && iss_ready
- iss_op  in  5  opcode, ALU encoding 0..18 (Fadd=0 … Vmin=18)
- iss_imm  in  8  immediate (Vindx/Vswizzle)
- iss_dst  in  TAG_W  destination tag
- iss_src1, iss_src2  in  TAG_W  source tags
- iss_src1_vec, iss_src2_vec  in  1  source is vector (1) or scalar (0) register
- iss_use_src2  in  1  src2 is read
- flush  in  1  drop all in-flight instructions
- alu_op  out  5  to ALU `op`
- alu_imm  out  8  to ALU `imm`
- alu_en  out  1  to ALU `en`
- wb_valid  out  1  result at ALU outputs is valid
- wb_ready  in  1  register file accepts writeback
- wb_dst  out  TAG_W  destination tag of retiring instruction
- wb_is_vec  out  1  1: take ALU `vout`; 0: take ALU `rout`
- illegal_op  out  1  one-cycle pulse: an accepted instruction had opcode > 18
- busy  out  1  any stage valid
- issued_cnt, retired_cnt  out  CNT_W  wrapping counters

## Operation
- Pipeline tracker has two stages, S1 and S2, mirroring the ALU registers. Each stage holds {valid, dst, is_vec, imm}.
- is_vec is derived from the opcode:
  - Ops 0,1,2,6,7,8,9 (Fadd, Fsub, Fmult, Vdot, Vdota, Vindx, Vreduce) write scalar (is_vec=0).
  - All other legal ops write vector (is_vec=1).
- stall = S2.valid && !wb_ready.
- alu_en = !stall. When alu_en=0, S1/S2 hold and iss_ready=0.
- Hazard detection:
  - hazard = iss_valid && a used source (src1 always; src2 if iss_use_src2) matches {dst, is_vec} of a valid entry in S1 or S2.
  - Source kind is compared with is_vec.
  - There is no forwarding, and the check is conservative even when S2 is retiring in the same cycle.
- iss_ready = !stall && !hazard && !flush.
- On accept with a legal opcode:
  - alu_op = iss_op.
  - S1 loads {1, iss_dst, is_vec, iss_imm}.
- On accept with an illegal opcode:
  - illegal_op pulses the next cycle.
  - S1 loads a bubble.
  - issued_cnt does not increment.
- When there is no accept and alu_en=1, alu_op=0 and S1 loads a bubble. The ALU computes an ignored Fadd.
- S2 <= S1 whenever alu_en=1.
- alu_imm is S2.imm, because the ALU samples imm at its output stage.
- wb_valid = S2.valid; wb_dst = S2.dst; wb_is_vec = S2.is_vec.
- Retire occurs when wb_valid && wb_ready; retired_cnt then increments.
- flush: at the next edge, S1.valid and S2.valid are cleared and counters keep their values. An iss_valid in the flush cycle is not accepted.
- busy = S1.valid || S2.valid.

## Timing
- Reset values: all stage valids=0, iss_ready=0 during rst, alu_en=0, alu_op=0, alu_imm=0, wb_valid=0, wb_dst=0, wb_is_vec=0, illegal_op=0, busy=0, both counters=0.
- First cycle after rst deassert: iss_ready=1 if iss_valid has no hazard.
- Latency: an instruction accepted in cycle N has wb_valid=1 in cycle N+2 (given no stall).
- Throughput: 1 per cycle for independent instructions.
- Dependent instructions: issue no earlier than N+3.
- Backpressure: while wb_ready=0 with S2 valid, the whole pipe and the ALU freeze. wb_valid/wb_dst remain stable until accepted.
- Retire and accept can occur in the same cycle.
- flush has priority over accept and stall. After flush, wb_valid=0 the next cycle, even if wb_ready was 0.
- rst mid-operation discards all in-flight instructions with no writeback.

## Test plan
- Independent stream: Vadd dst=1, Fmult dst=2, Vsub dst=3 on consecutive cycles with wb_ready=1 → wb_valid in cycles 2,3,4 with wb_dst 1,2,3 and wb_is_vec 1,0,1; issued_cnt=retired_cnt=3.
- RAW hazard: Vadd dst=v4 at cycle 0, then Vmult src1=v4 offered from cycle 1 → iss_ready=0 in cycles 1–2, accepted in cycle 3. Scalar r4 as source does not stall.
- Backpressure: fill S1/S2, hold wb_ready=0 for 4 cycles → alu_en=0, iss_ready=0, wb_dst stable. Release → two retires on consecutive cycles.
- Immediate alignment: Vswizzle imm=0x1B accepted at cycle 0, followed by Vindx imm=0x02 → alu_imm=0x1B in cycle 2 and 0x02 in cycle 3.
- Illegal op: iss_op=25 accepted → illegal_op pulse in cycle 1, no wb_valid, issued_cnt unchanged.
- Flush and reset: flush with both stages valid and wb_ready=0 → next cycle wb_valid=0, busy=0. Assert rst mid-stream → all outputs return to reset values on the next edge.
